// File: rtl/bram_fifo_pkg.sv
// Shared constants and helpers for the parity FIFO.
// Parity and prefetch ring utilities.
package bram_fifo_pkg;

  localparam int PREFETCH_DEPTH = 3;
  localparam int READ_LATENCY   = 2;

  function automatic logic par_byte(input logic [7:0] b);
    return ^b;
  endfunction

  function automatic logic [1:0] ring_inc(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

endpackage

// File: rtl/bram_fifo_parity_if.sv
// Producer/consumer bundle for the parity FIFO.
// master drives requests, slave is the FIFO.
interface bram_fifo_parity_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                    FLUSH;
  logic                    WR_EN;
  logic [DATA_WIDTH-1:0]   DIN;
  logic                    ERR_INJ;
  logic                    FULL;
  logic                    ALMOST_FULL;
  logic                    OVERFLOW;
  logic [DATA_WIDTH-1:0]   DOUT;
  logic                    DOUT_VALID;
  logic                    DOUT_READY;
  logic [DATA_WIDTH/8-1:0] PAR_ERR;
  logic                    ALMOST_EMPTY;
  logic [ADDR_WIDTH+1:0]   COUNT;

  modport master (
    output FLUSH, WR_EN, DIN, ERR_INJ, DOUT_READY,
    input  FULL, ALMOST_FULL, OVERFLOW, DOUT,
    input  DOUT_VALID, PAR_ERR, ALMOST_EMPTY, COUNT
  );

  modport slave (
    input  FLUSH, WR_EN, DIN, ERR_INJ, DOUT_READY,
    output FULL, ALMOST_FULL, OVERFLOW, DOUT,
    output DOUT_VALID, PAR_ERR, ALMOST_EMPTY, COUNT
  );
endinterface

// File: rtl/sdp_bram_reg.sv
// Simple-dual-port block RAM with output register.
// Array is never reset so it maps onto BRAM.
module sdp_bram_reg #(
  parameter int WIDTH = 18,
  parameter int AW    = 10
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [WIDTH-1:0] rd_q;
  logic [WIDTH-1:0] do_q;

  // array write, array read, then output register stage
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rd_q <= mem_q[raddr_i];
    do_q <= rd_q;
  end

  assign rdata_o = do_q;

endmodule

// File: rtl/bram_fifo_parity.sv
// FWFT FIFO on inferred SDP RAM with byte parity.
// A 3-entry ring hides the 2-cycle RAM latency.
module bram_fifo_parity
  import bram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 10,
  parameter int ALMOST_FULL_TH  = 1000,
  parameter int ALMOST_EMPTY_TH = 4
) (
  input logic               CLK,
  input logic               RST_N,
  bram_fifo_parity_if.slave bus
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int MW = DATA_WIDTH + NB;
  localparam int unsigned AFT = ALMOST_FULL_TH;
  localparam int unsigned AET = ALMOST_EMPTY_TH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W =
    {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] P1 =
    {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH+1:0] C1 =
    {{(ADDR_WIDTH+1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]     occ;
  logic [ADDR_WIDTH+1:0]   cnt_q, cnt_d;
  logic [READ_LATENCY-1:0] rv_q, rv_d;
  logic [1:0]              hd_q, hd_d;
  logic [1:0]              pc_q, pc_d;
  logic [1:0]              tl;
  logic [2:0]              tsum;
  logic [2:0]              infl;
  logic                    ovf_q, ovf_d;
  logic                    full, valid;
  logic                    wr_acc, rd_iss, pop, push;
  logic [MW-1:0]           wdata, rdata, head;
  logic [MW-1:0]           pf_q [PREFETCH_DEPTH];
  logic [NB-1:0]           par;

  assign occ    = wr_ptr_q - rd_ptr_q;
  assign full   = (occ == DEPTH_W);
  assign valid  = (pc_q != 2'd0);
  assign head   = pf_q[hd_q];
  assign wr_acc = bus.WR_EN && !full && !bus.FLUSH;
  assign pop    = valid && bus.DOUT_READY && !bus.FLUSH;
  assign push   = rv_q[READ_LATENCY-1] && !bus.FLUSH;

  // build stored word: data plus per-byte parity
  always_comb begin
    wdata = '0;
    wdata[DATA_WIDTH-1:0] = bus.DIN;
    for (int i = 0; i < NB; i++)
      wdata[DATA_WIDTH+i] = par_byte(bus.DIN[8*i +: 8]);
    wdata[DATA_WIDTH] = wdata[DATA_WIDTH] ^ bus.ERR_INJ;
  end

  // reads in flight and ring tail; a same-cycle pop frees a slot
  always_comb begin
    infl = '0;
    for (int i = 0; i < READ_LATENCY; i++)
      infl = infl + {2'b00, rv_q[i]};
    tsum = {1'b0, hd_q} + {1'b0, pc_q};
    tl = (tsum >= 3'd3) ? 2'(tsum - 3'd3) : tsum[1:0];
    rd_iss = !bus.FLUSH && (occ != '0) &&
      ((infl + {1'b0, pc_q}) <
       (3'(PREFETCH_DEPTH) + {2'b00, pop}));
  end

  // next-state for pointers, counters and ring bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    hd_d     = hd_q;
    pc_d     = pc_q;
    rv_d     = {rv_q[READ_LATENCY-2:0], rd_iss};
    ovf_d    = bus.WR_EN && full && !bus.FLUSH;
    if (bus.FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      hd_d     = '0;
      pc_d     = '0;
      rv_d     = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + P1;
      if (rd_iss) rd_ptr_d = rd_ptr_q + P1;
      if (wr_acc && !pop) cnt_d = cnt_q + C1;
      if (!wr_acc && pop) cnt_d = cnt_q - C1;
      if (pop) hd_d = ring_inc(hd_q);
      if (push && !pop) pc_d = pc_q + 2'd1;
      if (!push && pop) pc_d = pc_q - 2'd1;
    end
  end

  // control state registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      hd_q     <= '0;
      pc_q     <= '0;
      rv_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      hd_q     <= hd_d;
      pc_q     <= pc_d;
      rv_q     <= rv_d;
      ovf_q    <= ovf_d;
    end
  end

  // prefetch ring storage, landing RAM words at the tail
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < PREFETCH_DEPTH; i++)
        pf_q[i] <= '0;
    end else if (push) begin
      pf_q[tl] <= rdata;
    end
  end

  sdp_bram_reg #(
    .WIDTH (MW),
    .AW    (ADDR_WIDTH)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (wdata),
    .re_i    (rd_iss),
    .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (rdata)
  );

  // parity recheck of the head word
  always_comb begin
    par = '0;
    if (valid)
      for (int i = 0; i < NB; i++)
        par[i] = head[DATA_WIDTH+i] ^
                 par_byte(head[8*i +: 8]);
  end

  assign bus.DOUT         = head[DATA_WIDTH-1:0];
  assign bus.DOUT_VALID   = valid;
  assign bus.PAR_ERR      = par;
  assign bus.FULL         = full;
  assign bus.ALMOST_FULL  = (32'(occ) >= AFT);
  assign bus.OVERFLOW     = ovf_q;
  assign bus.COUNT        = cnt_q;
  assign bus.ALMOST_EMPTY = (32'(cnt_q) <= AET);

endmodule

// File: tb/tb_bram_fifo_parity.sv
// Directed bench for bram_fifo_parity.
// Depth 16 geometry, one task per scenario.
module tb_bram_fifo_parity;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  bram_fifo_parity_if #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (4)
  ) bus ();

  bram_fifo_parity #(
    .DATA_WIDTH      (16),
    .ADDR_WIDTH      (4),
    .ALMOST_FULL_TH  (14),
    .ALMOST_EMPTY_TH (4)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.FLUSH = 0; bus.WR_EN = 0; bus.DIN = '0;
    bus.ERR_INJ = 0; bus.DOUT_READY = 0;
    #3;
    checks++;
    if (bus.DOUT_VALID !== 1'b0 || bus.DOUT !== 16'h0 ||
        bus.PAR_ERR !== 2'b00) begin
      errors++;
      $display("FAIL reset_out: valid=%b dout=%h par=%b want 0/0000/00",
               bus.DOUT_VALID, bus.DOUT, bus.PAR_ERR);
    end
    checks++;
    if (bus.FULL !== 1'b0 || bus.ALMOST_FULL !== 1'b0 ||
        bus.OVERFLOW !== 1'b0 || bus.COUNT !== 6'd0 ||
        bus.ALMOST_EMPTY !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: f=%b af=%b ov=%b cnt=%0d ae=%b want 0 0 0 0 1",
               bus.FULL, bus.ALMOST_FULL, bus.OVERFLOW,
               bus.COUNT, bus.ALMOST_EMPTY);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus.DOUT_READY = 1; bus.WR_EN = 1; bus.DIN = 16'h1234;
    tick();
    bus.WR_EN = 0;
    checks++;
    if (bus.COUNT !== 6'd1 || bus.DOUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL single_t0: cnt=%0d valid=%b want 1 0",
               bus.COUNT, bus.DOUT_VALID);
    end
    tick(); tick();
    checks++;
    if (bus.DOUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL single_early: valid=%b want 0", bus.DOUT_VALID);
    end
    tick();
    checks++;
    if (bus.DOUT_VALID !== 1'b1 || bus.DOUT !== 16'h1234 ||
        bus.PAR_ERR !== 2'b00) begin
      errors++;
      $display("FAIL single_out: valid=%b dout=%h par=%b want 1 1234 00",
               bus.DOUT_VALID, bus.DOUT, bus.PAR_ERR);
    end
    tick();
    checks++;
    if (bus.DOUT_VALID !== 1'b0 || bus.COUNT !== 6'd0) begin
      errors++;
      $display("FAIL single_pop: valid=%b cnt=%0d want 0 0",
               bus.DOUT_VALID, bus.COUNT);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] exp;
    int cyc;
    bus.DOUT_READY = 0;
    for (int k = 0; k < 20; k++) begin
      bus.WR_EN = 1; bus.DIN = 16'(k);
      tick();
      checks++;
      if (bus.FULL !== (k >= 18)) begin
        errors++;
        $display("FAIL ovf_full k=%0d: got %b want %b",
                 k, bus.FULL, (k >= 18));
      end
      checks++;
      if (bus.OVERFLOW !== (k == 19)) begin
        errors++;
        $display("FAIL ovf_pulse k=%0d: got %b want %b",
                 k, bus.OVERFLOW, (k == 19));
      end
    end
    bus.WR_EN = 0;
    checks++;
    if (bus.COUNT !== 6'd19 || bus.ALMOST_FULL !== 1'b1) begin
      errors++;
      $display("FAIL ovf_count: cnt=%0d af=%b want 19 1",
               bus.COUNT, bus.ALMOST_FULL);
    end
    tick();
    checks++;
    if (bus.OVERFLOW !== 1'b0 || bus.DOUT_VALID !== 1'b1 ||
        bus.DOUT !== 16'h0) begin
      errors++;
      $display("FAIL ovf_hold: ov=%b valid=%b dout=%h want 0 1 0000",
               bus.OVERFLOW, bus.DOUT_VALID, bus.DOUT);
    end
    bus.DOUT_READY = 1;
    exp = 16'h0;
    cyc = 0;
    while (exp < 16'd19 && cyc < 80) begin
      if (bus.DOUT_VALID === 1'b1) begin
        checks++;
        if (bus.DOUT !== exp) begin
          errors++;
          $display("FAIL ovf_drain: got %h want %h", bus.DOUT, exp);
        end
        exp++;
      end
      tick();
      cyc++;
    end
    checks++;
    if (exp != 16'd19 || bus.COUNT !== 6'd0 ||
        bus.DOUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drain_end: words=%0d cnt=%0d valid=%b want 19 0 0",
               exp, bus.COUNT, bus.DOUT_VALID);
    end
  endtask

  task automatic test_back_to_back();
    bus.DOUT_READY = 1;
    for (int i = 0; i < 104; i++) begin
      bus.WR_EN = (i < 100);
      bus.DIN = 16'(16'h0100 + i);
      tick();
      if (i >= 3 && i < 103) begin
        checks++;
        if (bus.DOUT_VALID !== 1'b1 ||
            bus.DOUT !== 16'(16'h0100 + i - 3)) begin
          errors++;
          $display("FAIL stream i=%0d: valid=%b dout=%h want 1 %h",
                   i, bus.DOUT_VALID, bus.DOUT, 16'(16'h0100 + i - 3));
        end
      end
    end
    bus.WR_EN = 0;
    checks++;
    if (bus.DOUT_VALID !== 1'b0 || bus.COUNT !== 6'd0) begin
      errors++;
      $display("FAIL stream_end: valid=%b cnt=%0d want 0 0",
               bus.DOUT_VALID, bus.COUNT);
    end
  endtask

  task automatic test_parity();
    bus.DOUT_READY = 0;
    bus.WR_EN = 1; bus.DIN = 16'h00FF; bus.ERR_INJ = 1;
    tick();
    bus.DIN = 16'h0101; bus.ERR_INJ = 0;
    tick();
    bus.WR_EN = 0;
    tick(); tick(); tick();
    checks++;
    if (bus.DOUT_VALID !== 1'b1 || bus.DOUT !== 16'h00FF ||
        bus.PAR_ERR !== 2'b01) begin
      errors++;
      $display("FAIL par_inj: valid=%b dout=%h par=%b want 1 00ff 01",
               bus.DOUT_VALID, bus.DOUT, bus.PAR_ERR);
    end
    bus.DOUT_READY = 1;
    tick();
    checks++;
    if (bus.DOUT_VALID !== 1'b1 || bus.DOUT !== 16'h0101 ||
        bus.PAR_ERR !== 2'b00) begin
      errors++;
      $display("FAIL par_clean: valid=%b dout=%h par=%b want 1 0101 00",
               bus.DOUT_VALID, bus.DOUT, bus.PAR_ERR);
    end
    tick();
    checks++;
    if (bus.COUNT !== 6'd0) begin
      errors++;
      $display("FAIL par_end: cnt=%0d want 0", bus.COUNT);
    end
  endtask

  task automatic test_flush();
    bit seen;
    bus.DOUT_READY = 0;
    for (int k = 0; k < 8; k++) begin
      bus.WR_EN = 1; bus.DIN = 16'(16'h0010 + k);
      tick();
    end
    bus.DIN = 16'hAAAA; bus.FLUSH = 1; bus.DOUT_READY = 1;
    tick();
    bus.FLUSH = 0; bus.WR_EN = 0;
    checks++;
    if (bus.COUNT !== 6'd0 || bus.DOUT_VALID !== 1'b0 ||
        bus.FULL !== 1'b0 || bus.ALMOST_EMPTY !== 1'b1) begin
      errors++;
      $display("FAIL flush_now: cnt=%0d valid=%b full=%b ae=%b want 0 0 0 1",
               bus.COUNT, bus.DOUT_VALID, bus.FULL, bus.ALMOST_EMPTY);
    end
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.DOUT_VALID === 1'b1) seen = 1;
    end
    checks++;
    if (seen !== 1'b0 || bus.COUNT !== 6'd0) begin
      errors++;
      $display("FAIL flush_after: seen_valid=%b cnt=%0d want 0 0",
               seen, bus.COUNT);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bus.DOUT_READY = 0;
    bus.WR_EN = 1; bus.DIN = 16'h1111;
    tick();
    bus.DIN = 16'h2222;
    tick();
    bus.WR_EN = 0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.COUNT !== 6'd0 || bus.DOUT_VALID !== 1'b0 ||
        bus.DOUT !== 16'h0 || bus.PAR_ERR !== 2'b00 ||
        bus.FULL !== 1'b0 || bus.OVERFLOW !== 1'b0 ||
        bus.ALMOST_EMPTY !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: cnt=%0d valid=%b dout=%h par=%b f=%b ov=%b ae=%b",
               bus.COUNT, bus.DOUT_VALID, bus.DOUT, bus.PAR_ERR,
               bus.FULL, bus.OVERFLOW, bus.ALMOST_EMPTY);
    end
    tick(); tick();
    checks++;
    if (bus.DOUT_VALID !== 1'b0 || bus.COUNT !== 6'd0) begin
      errors++;
      $display("FAIL rst_hold: valid=%b cnt=%0d want 0 0",
               bus.DOUT_VALID, bus.COUNT);
    end
    rst_n = 1'b1;
    tick();
    bus.DOUT_READY = 1;
    bus.WR_EN = 1; bus.DIN = 16'h5A5A;
    tick();
    bus.WR_EN = 0;
    cyc = 0;
    while (bus.DOUT_VALID !== 1'b1 && cyc < 10) begin
      tick();
      cyc++;
    end
    checks++;
    if (bus.DOUT_VALID !== 1'b1 || bus.DOUT !== 16'h5A5A) begin
      errors++;
      $display("FAIL rst_first: valid=%b dout=%h want 1 5a5a",
               bus.DOUT_VALID, bus.DOUT);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_parity();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
